// File: rtl/icache_axi_bridge.sv
// Instruction-cache line refill bridge: one 16-beat INCR AXI4 read burst per cache miss.
// Beats are registered toward the cache; abandoned requests are drained off the bus silently.
module icache_axi_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr_mmu,
    input  logic        inst_read_req,
    output logic        inst_addr_ok,
    output logic [31:0] inst_read_data,
    output logic        mmu_valid,
    output logic        mmu_last,
    output logic        inst_bus_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_e;

    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFC0;

    state_e      state_q, state_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        bus_err_q, bus_err_d;

    logic own_beat, foreign_beat, beat_err, at_last, addr_match;

    assign own_beat     = rvalid && (rid == AXI_ID);
    assign foreign_beat = rvalid && (rid != AXI_ID);
    assign at_last      = (cnt_q == 4'd15);
    assign beat_err     = (rresp != 2'b00) || (rlast != at_last);
    assign addr_match   = ((inst_addr_mmu & LINE_MASK) == req_addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_addr_q <= req_addr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            bus_err_q  <= bus_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        last_d       = 1'b0;
        bus_err_d    = 1'b0;
        arvalid      = 1'b0;
        araddr       = '0;
        rready       = 1'b0;
        inst_addr_ok = 1'b0;

        case (state_q)
            IDLE: begin
                if (inst_read_req) begin
                    req_addr_d = inst_addr_mmu & LINE_MASK;
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                arvalid = 1'b1;
                araddr  = req_addr_q;
                if (arready) begin
                    cnt_d = '0;
                    // The AR handshake is committed either way; a stale request still needs its beats drained.
                    if (inst_read_req && addr_match) begin
                        inst_addr_ok = 1'b1;
                        err_d        = 1'b0;
                        state_d      = DATA;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DATA: begin
                rready = 1'b1;
                if (foreign_beat) begin
                    err_d = 1'b1;
                end else if (own_beat) begin
                    data_d    = rdata;
                    valid_d   = 1'b1;
                    last_d    = at_last;
                    bus_err_d = at_last && (err_q || beat_err);
                    err_d     = err_q || beat_err;
                    cnt_d     = cnt_q + 4'd1;
                    if (at_last) state_d = IDLE;
                end
            end
            DRAIN: begin
                rready = 1'b1;
                if (own_beat) begin
                    cnt_d = cnt_q + 4'd1;
                    if (at_last) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign inst_read_data = data_q;
    assign mmu_valid      = valid_q;
    assign mmu_last       = last_q;
    assign inst_bus_err   = bus_err_q;
    assign arid           = AXI_ID;
    assign arlen          = 8'd15;
    assign arsize         = 3'b010;
    assign arburst        = 2'b01;

endmodule

// File: tb/tb_icache_axi_bridge.sv
// Directed bench for icache_axi_bridge: a per-cycle vector table for the basic burst,
// then hand-written sequences for backpressure, withdrawal, error, gaps and mid-burst reset.
module tb_icache_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr_mmu;
    logic        inst_read_req;
    logic        inst_addr_ok;
    logic [31:0] inst_read_data;
    logic        mmu_valid, mmu_last, inst_bus_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    icache_axi_bridge #(.AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst),
        .inst_addr_mmu(inst_addr_mmu), .inst_read_req(inst_read_req),
        .inst_addr_ok(inst_addr_ok), .inst_read_data(inst_read_data),
        .mmu_valid(mmu_valid), .mmu_last(mmu_last), .inst_bus_err(inst_bus_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst, req;
        logic [31:0] addr;
        logic        arready, rvalid;
        logic [31:0] rdata;
        logic        rlast;
        logic        e_arvalid;
        logic [31:0] e_araddr;
        logic        e_ok, e_rready, e_valid;
        logic [31:0] e_data;
        logic        e_last, e_err;
    } vec_t;

    function automatic vec_t mk(input logic rs, input logic rq, input logic [31:0] a,
                                input logic ar, input logic rv, input logic [31:0] d,
                                input logic rl, input logic ev, input logic [31:0] ea,
                                input logic eok, input logic err, input logic evl,
                                input logic [31:0] ed, input logic el, input logic ee);
        vec_t v;
        v.rst = rs; v.req = rq; v.addr = a; v.arready = ar; v.rvalid = rv;
        v.rdata = d; v.rlast = rl; v.e_arvalid = ev; v.e_araddr = ea; v.e_ok = eok;
        v.e_rready = err; v.e_valid = evl; v.e_data = ed; v.e_last = el; v.e_err = ee;
        return v;
    endfunction

    // Beat-stream capture shared by step/feed
    logic [31:0] got[$];
    logic [15:0] last_mask, err_mask;
    int          stray, rr_bad;

    task automatic step(input logic rv, input logic [3:0] id, input logic [31:0] d,
                        input logic [1:0] resp, input logic rl);
        @(negedge clk);
        inst_read_req = 1'b0; arready = 1'b0;
        rvalid = rv; rid = id; rdata = d; rresp = resp; rlast = rl;
        #1;
        if (rv && !rready) rr_bad++;
        if (mmu_valid) begin
            if (got.size() < 16) begin
                last_mask[got.size()] = mmu_last;
                err_mask[got.size()]  = inst_bus_err;
            end
            got.push_back(inst_read_data);
        end else if (mmu_last || inst_bus_err) begin
            stray++;
        end
    endtask

    task automatic start(input logic [31:0] a, input int stall, input logic keep, input string tag);
        @(negedge clk);
        inst_read_req = 1'b1; inst_addr_mmu = a; arready = 1'b0; rvalid = 1'b0;
        #1 chk({tag, "_idle_arvalid"}, {63'd0, arvalid}, 64'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            arready = 1'b0;
            #1 chk($sformatf("%s_stall%0d", tag, i), {arvalid, inst_addr_ok, araddr},
                   {1'b1, 1'b0, a & 32'hFFFF_FFC0});
        end
        @(negedge clk);
        arready = 1'b1; inst_read_req = keep;
        #1 chk({tag, "_ar_hs"}, {arvalid, inst_addr_ok, araddr}, {1'b1, keep, a & 32'hFFFF_FFC0});
    endtask

    task automatic feed(input logic [31:0] base, input bit gaps, input int foreign_at,
                        input int err_at, input int exp_n, input bit exp_err, input string tag);
        got.delete(); last_mask = '0; err_mask = '0; stray = 0; rr_bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (k == foreign_at) step(1'b1, 4'd5, 32'hDEAD_BEEF, 2'b00, 1'b0);
            step(1'b1, 4'd0, base + k, (k == err_at) ? 2'b10 : 2'b00, k == 15);
            if (gaps) step(1'b0, 4'd0, 32'd0, 2'b00, 1'b0);
        end
        step(1'b0, 4'd0, 32'd0, 2'b00, 1'b0);
        step(1'b0, 4'd0, 32'd0, 2'b00, 1'b0);
        chk({tag, "_beats"}, got.size(), exp_n);
        for (int i = 0; i < got.size() && i < exp_n; i++)
            chk($sformatf("%s_data%0d", tag, i), got[i], base + i);
        chk({tag, "_last_mask"}, last_mask, (exp_n == 16) ? 16'h8000 : 16'h0);
        chk({tag, "_err_mask"}, err_mask, (exp_n == 16 && exp_err) ? 16'h8000 : 16'h0);
        chk({tag, "_stray"}, stray, 0);
        chk({tag, "_rready_beats"}, rr_bad, 0);
        chk({tag, "_idle_after"}, {62'd0, rready, arvalid}, 64'd0);
    endtask

    initial begin
        vec_t tbl[$];
        rst = 1'b1; inst_addr_mmu = '0; inst_read_req = 1'b0; arready = 1'b0;
        rid = 4'd0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;

        // Basic burst at 0x1FC0_0044, arready in the first ADDR cycle, back-to-back beats
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h1FC0_0044, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h1FC0_0044, 1, 0, 0, 0,   1, 32'h1FC0_0040, 1, 0, 0, 0, 0, 0));
        for (int k = 0; k < 16; k++)
            tbl.push_back(mk(0, 0, 0, 0, 1, k, k == 15,   0, 0, 0, 1, k > 0, k - 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 32'd15, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));

        repeat (2) @(posedge clk);
        #1 chk("reset_consts", {arid, arlen, arsize, arburst}, {4'd0, 8'd15, 3'd2, 2'd1});

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; inst_read_req = tbl[i].req; inst_addr_mmu = tbl[i].addr;
            arready = tbl[i].arready; rvalid = tbl[i].rvalid; rdata = tbl[i].rdata;
            rlast = tbl[i].rlast; rid = 4'd0; rresp = 2'b00;
            #1;
            chk($sformatf("vec%0d_ctl", i),
                {arvalid, inst_addr_ok, rready, mmu_valid, mmu_last, inst_bus_err, araddr},
                {tbl[i].e_arvalid, tbl[i].e_ok, tbl[i].e_rready, tbl[i].e_valid,
                 tbl[i].e_last, tbl[i].e_err, tbl[i].e_araddr});
            if (tbl[i].e_valid) chk($sformatf("vec%0d_data", i), inst_read_data, tbl[i].e_data);
        end

        // AR backpressure: 5 stalled ADDR cycles
        start(32'h0000_1234, 5, 1'b1, "bp");
        feed(32'h100, 1'b0, -1, -1, 16, 1'b0, "bp");

        // Request withdrawn during ADDR: burst drained silently
        start(32'h0000_2000, 1, 1'b0, "wd");
        feed(32'h200, 1'b0, -1, -1, 0, 1'b0, "wd");

        // Error response on beat 3
        start(32'h0000_3000, 0, 1'b1, "er");
        feed(32'h300, 1'b0, -1, 3, 16, 1'b1, "er");

        // rvalid gaps with one foreign-id beat (which also flags the line)
        start(32'h0000_4000, 0, 1'b1, "gap");
        feed(32'h400, 1'b1, 6, -1, 16, 1'b1, "gap");

        // Clean burst after an errored one: sticky bit must have cleared
        start(32'h0000_5000, 0, 1'b1, "clr");
        feed(32'h500, 1'b0, -1, -1, 16, 1'b0, "clr");

        // Reset while beat 7 is on the bus
        start(32'h0000_6000, 0, 1'b1, "rst");
        for (int k = 0; k < 7; k++) step(1'b1, 4'd0, 32'h600 + k, 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b1; rvalid = 1'b1; rdata = 32'h607;
        @(negedge clk);
        rst = 1'b0; rvalid = 1'b0;
        #1 chk("rst_outputs",
               {arvalid, inst_addr_ok, rready, mmu_valid, mmu_last, inst_bus_err, araddr, inst_read_data},
               64'd0);
        start(32'h0000_7040, 0, 1'b1, "post");
        feed(32'h700, 1'b0, -1, -1, 16, 1'b0, "post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
